// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the 5-stage pipeline.
//   XLEN          datapath width
//   NOP_INSTR     instruction word used for pipeline bubbles
//   fetch_state_t fetch control FSM states {IDLE, RUN, HALT}
//   stage_ctrl_t  pipeline-register control {load, hold, bubble}
//   if_id_t       IF/ID pipeline register contents {instr, pc, valid}
//   IF_ID_BUBBLE  IF/ID value for an empty slot (also the reset value)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_t;

  typedef enum logic [1:0] {
    REG_LOAD,
    REG_HOLD,
    REG_BUBBLE
  } stage_ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with load / hold / bubble control. Written around a
// generic control enum so the later stage registers can follow the same shape.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   asynchronous reset, active-low (clears to a bubble)
//   ctrl  in   REG_LOAD: q<=d, REG_HOLD: q holds, REG_BUBBLE: q<=IF_ID_BUBBLE
//   d     in   next IF/ID contents
//   q     out  registered IF/ID contents
// -----------------------------------------------------------------------------
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  stage_ctrl_t ctrl,
  input  if_id_t      d,
  output if_id_t      q
);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= IF_ID_BUBBLE;
    end else begin
      case (ctrl)
        REG_LOAD:   q <= d;
        REG_BUBBLE: q <= IF_ID_BUBBLE;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// IF stage: PC register, start/halt control FSM, instruction-memory addressing
// and the IF/ID pipeline register feeding ID.
// Parameters:
//   RESET_PC    PC loaded on reset
//   IMEM_DEPTH  instruction memory words; imem_addr = pc mod IMEM_DEPTH
//   HALT_INSTR  instruction word that stops fetch
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous reset, active-low
//   start          in   level; leaves IDLE when high
//   stall          in   hold PC and IF/ID (from hazard unit)
//   flush          in   taken branch in EX; redirect PC and kill IF/ID
//   branch_target  in   redirect PC
//   imem_addr      out  word address to instruction ROM (combinational read)
//   imem_rdata     in   instruction at imem_addr, same cycle
//   instr_id       out  IF/ID instruction (NOP_INSTR when bubble)
//   pc_id          out  IF/ID PC of instr_id
//   valid_id       out  instr_id is a real instruction
//   running        out  state == RUN
//   halted         out  state == HALT
// Configuration:
//   FETCH_PERF_EN  adds perf_fetch_cnt (RUN edges that loaded a valid instr)
//                  and perf_stall_cnt (RUN edges with stall=1, flush=0).
// -----------------------------------------------------------------------------
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_DEPTH = 256,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          stall,
  input  logic                          flush,
  input  logic [31:0]                   branch_target,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [31:0]                   imem_rdata,
  output logic [31:0]                   instr_id,
  output logic [31:0]                   pc_id,
  output logic                          valid_id,
  output logic                          running,
  output logic                          halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                   perf_fetch_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);

  localparam int AW = $clog2(IMEM_DEPTH);

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  stage_ctrl_t     id_ctrl;
  if_id_t          id_d, id_q;

  // NOTE: reset is asynchronous; PC and state take their reset values the
  // moment rst falls, not at the next clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  // Next-state, next-PC and IF/ID control. Priority in RUN is
  // flush > stall > halt detection > normal fetch.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned and infer a latch.
    state_next = state;
    pc_next    = pc;
    id_ctrl    = REG_BUBBLE;
    id_d       = '{instr: imem_rdata, pc: pc, valid: 1'b1};

    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (flush) begin
          pc_next = branch_target;
        end else if (stall) begin
          id_ctrl = REG_HOLD;
        end else if (imem_rdata == HALT_INSTR) begin
          // PC stays on the halt word so imem_addr points at it while halted.
          state_next = HALT;
        end else begin
          id_ctrl = REG_LOAD;
          pc_next = pc + 32'd1;
        end
      end
      HALT: begin
        // An older branch can still resolve after the halt word was fetched;
        // that redirect must resume fetching.
        if (flush) begin
          pc_next    = branch_target;
          state_next = RUN;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk  (clk),
    .rst  (rst),
    .ctrl (id_ctrl),
    .d    (id_d),
    .q    (id_q)
  );

  assign imem_addr = pc[AW-1:0];
  assign instr_id  = id_q.instr;
  assign pc_id     = id_q.pc;
  assign valid_id  = id_q.valid;
  assign running   = (state == RUN);
  assign halted    = (state == HALT);

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (state == RUN) begin
      if (id_ctrl == REG_LOAD) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall && !flush)     perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage with a 256-word ROM where ROM[i] = i+1.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_id;
  logic [31:0] pc_id;
  logic        valid_id;
  logic        running;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  logic [31:0] rom [0:255];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign imem_rdata = rom[imem_addr];

  fetch_stage #(
    .RESET_PC   (32'h0),
    .IMEM_DEPTH (256),
    .HALT_INSTR (32'hFFFF_FFFF)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .instr_id      (instr_id),
    .pc_id         (pc_id),
    .valid_id      (valid_id),
    .running       (running),
    .halted        (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pipeline view packed as {halted, running, valid, pc_id, instr_id}.
  function automatic logic [66:0] view();
    return {halted, running, valid_id, pc_id, instr_id};
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; stall = 1'b0; flush = 1'b0; branch_target = '0;
    #12;
    n_cmp++;
    if (view() !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_state: got %h expected %h", view(), 67'h0);
    end
    n_cmp++;
    if (imem_addr !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_addr: got %h expected 00", imem_addr);
    end
    rst = 1'b1;
  endtask

  task automatic test_fetch();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({running, valid_id, imem_addr} !== {1'b1, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL start_run: got run=%b valid=%b addr=%h expected run=1 valid=0 addr=00",
               running, valid_id, imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (view() !== {1'b0, 1'b1, 1'b1, 32'(i), 32'(i + 1)}) begin
        n_bad++;
        $display("FAIL fetch_seq[%0d]: got %h expected %h", i, view(),
                 {1'b0, 1'b1, 1'b1, 32'(i), 32'(i + 1)});
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({valid_id, pc_id, instr_id, imem_addr} !== {1'b1, 32'd4, 32'd5, 8'd5}) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got valid=%b pc=%h instr=%h addr=%h expected 1/4/5/05",
                 i, valid_id, pc_id, instr_id, imem_addr);
      end
    end
    stall = 1'b0;
    for (int i = 5; i < 7; i++) begin
      tick();
      n_cmp++;
      if ({valid_id, pc_id, instr_id} !== {1'b1, 32'(i), 32'(i + 1)}) begin
        n_bad++;
        $display("FAIL stall_resume[%0d]: got pc=%h instr=%h expected pc=%h instr=%h",
                 i, pc_id, instr_id, i, i + 1);
      end
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; stall = 1'b1; branch_target = 32'h20;
    tick();
    flush = 1'b0; stall = 1'b0;
    n_cmp++;
    if ({running, valid_id, imem_addr} !== {1'b1, 1'b0, 8'h20}) begin
      n_bad++;
      $display("FAIL flush_kill: got run=%b valid=%b addr=%h expected run=1 valid=0 addr=20",
               running, valid_id, imem_addr);
    end
    tick();
    n_cmp++;
    if ({valid_id, pc_id, instr_id} !== {1'b1, 32'h20, 32'h21}) begin
      n_bad++;
      $display("FAIL flush_target: got pc=%h instr=%h expected pc=20 instr=21", pc_id, instr_id);
    end
  endtask

  task automatic test_wrap();
    flush = 1'b1; branch_target = 32'hFFFF_FFFF;
    tick();
    flush = 1'b0;
    n_cmp++;
    if ({valid_id, imem_addr} !== {1'b0, 8'hFF}) begin
      n_bad++;
      $display("FAIL wrap_addr: got valid=%b addr=%h expected valid=0 addr=ff", valid_id, imem_addr);
    end
    tick();
    n_cmp++;
    if ({valid_id, pc_id, instr_id, imem_addr} !== {1'b1, 32'hFFFF_FFFF, 32'h100, 8'h00}) begin
      n_bad++;
      $display("FAIL wrap_top: got pc=%h instr=%h addr=%h expected pc=ffffffff instr=100 addr=00",
               pc_id, instr_id, imem_addr);
    end
    tick();
    n_cmp++;
    if ({valid_id, pc_id, instr_id} !== {1'b1, 32'h0, 32'h1}) begin
      n_bad++;
      $display("FAIL wrap_zero: got pc=%h instr=%h expected pc=0 instr=1", pc_id, instr_id);
    end
  endtask

  task automatic test_halt();
    rom[7] = 32'hFFFF_FFFF;
    flush = 1'b1; branch_target = 32'd5;
    tick();
    flush = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({valid_id, pc_id, instr_id} !== {1'b1, 32'd6, 32'd7}) begin
      n_bad++;
      $display("FAIL halt_pre: got pc=%h instr=%h expected pc=6 instr=7", pc_id, instr_id);
    end
    tick();
    n_cmp++;
    if ({halted, running, valid_id, imem_addr} !== {1'b1, 1'b0, 1'b0, 8'd7}) begin
      n_bad++;
      $display("FAIL halt_enter: got halt=%b run=%b valid=%b addr=%h expected 1/0/0/07",
               halted, running, valid_id, imem_addr);
    end
    start = 1'b1; stall = 1'b1;
    tick();
    start = 1'b0; stall = 1'b0;
    n_cmp++;
    if ({halted, valid_id, imem_addr} !== {1'b1, 1'b0, 8'd7}) begin
      n_bad++;
      $display("FAIL halt_sticky: got halt=%b valid=%b addr=%h expected 1/0/07",
               halted, valid_id, imem_addr);
    end
    flush = 1'b1; branch_target = 32'd3;
    tick();
    flush = 1'b0;
    n_cmp++;
    if ({halted, running, valid_id, imem_addr} !== {1'b0, 1'b1, 1'b0, 8'd3}) begin
      n_bad++;
      $display("FAIL halt_exit: got halt=%b run=%b valid=%b addr=%h expected 0/1/0/03",
               halted, running, valid_id, imem_addr);
    end
    tick();
    n_cmp++;
    if ({valid_id, pc_id, instr_id} !== {1'b1, 32'd3, 32'd4}) begin
      n_bad++;
      $display("FAIL halt_resume: got pc=%h instr=%h expected pc=3 instr=4", pc_id, instr_id);
    end
  endtask

  task automatic test_async_reset();
    tick();
    #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({view(), imem_addr} !== {67'h0, 8'h00}) begin
      n_bad++;
      $display("FAIL async_reset: got %h addr=%h expected all zero", view(), imem_addr);
    end
    #2;
    rst = 1'b1;
    flush = 1'b1; stall = 1'b1; branch_target = 32'h40;
    tick();
    flush = 1'b0; stall = 1'b0;
    n_cmp++;
    if ({running, valid_id, imem_addr} !== {1'b0, 1'b0, 8'h00}) begin
      n_bad++;
      $display("FAIL idle_ignore: got run=%b valid=%b addr=%h expected 0/0/00",
               running, valid_id, imem_addr);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    n_cmp++;
    if ({running, valid_id, pc_id, instr_id} !== {1'b1, 1'b1, 32'h0, 32'h1}) begin
      n_bad++;
      $display("FAIL restart: got run=%b valid=%b pc=%h instr=%h expected 1/1/0/1",
               running, valid_id, pc_id, instr_id);
    end
  endtask

`ifdef FETCH_PERF_EN
  task automatic test_perf();
    #2;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt} !== 64'h0) begin
      n_bad++;
      $display("FAIL perf_reset: got fetch=%0d stall=%0d expected 0/0", perf_fetch_cnt, perf_stall_cnt);
    end
    for (int e = 0; e < 10; e++) begin
      stall = (e >= 3 && e <= 5);
      tick();
    end
    stall = 1'b0;
    n_cmp++;
    if ({perf_fetch_cnt, perf_stall_cnt} !== {32'd7, 32'd3}) begin
      n_bad++;
      $display("FAIL perf_counts: got fetch=%0d stall=%0d expected 7/3", perf_fetch_cnt, perf_stall_cnt);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'(i + 1);
    test_reset();
    test_fetch();
    test_stall();
    test_flush();
    test_wrap();
    test_halt();
    test_async_reset();
`ifdef FETCH_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
